// File: rtl/mul_seq_arb_if.sv
// Signal bundle between the requester pair, the result consumer, the shared 16x16 multiplier cell
// and the sequencer. The master side is the environment; the slave side is the sequencer.
interface mul_seq_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [1:0]  req1_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_en;
    logic [31:0] mul_p;

    modport master (
        output req0_valid, req0_src1, req0_src2, req0_op,
        output req1_valid, req1_src1, req1_src2, req1_op,
        output rsp_ready, mul_p,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        input  mul_a, mul_b, mul_en
    );

    modport slave (
        input  req0_valid, req0_src1, req0_src2, req0_op,
        input  req1_valid, req1_src1, req1_src2, req1_op,
        input  rsp_ready, mul_p,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data,
        output mul_a, mul_b, mul_en
    );
endinterface

// File: rtl/mul_seq_arb.sv
// Two-requester arbiter and sequencer that builds 32x32 multiplies (low word or one of three
// high-word variants) from partial products of one shared, registered 16x16 multiplier cell.
module mul_seq_arb #(
    parameter bit HI_OPS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mul_seq_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, ACC, FIX, RSP} state_t;

    localparam logic [1:0] OP_LO = 2'b00;
    localparam logic [1:0] OP_SS = 2'b10;
    localparam logic [1:0] OP_SU = 2'b11;

    state_t      state_reg, state_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [1:0]  op_reg, op_next;
    logic        id_reg, id_next;
    logic        last_grant_reg, last_grant_next;
    logic [63:0] acc_reg, acc_next;
    logic [15:0] mul_a_reg, mul_a_next;
    logic [15:0] mul_b_reg, mul_b_next;
    logic        mul_en_reg, mul_en_next;

    logic        grant0, grant1, is_lo;
    logic [31:0] src1_sel, src2_sel, fix_sub;
    logic [1:0]  op_sel, op_in;
    logic [63:0] prod_ext;

    // Round-robin on contention: the requester that did not win last time goes first.
    assign grant0   = bus.req0_valid & (~bus.req1_valid | last_grant_reg);
    assign grant1   = bus.req1_valid & (~bus.req0_valid | ~last_grant_reg);
    assign src1_sel = grant1 ? bus.req1_src1 : bus.req0_src1;
    assign src2_sel = grant1 ? bus.req1_src2 : bus.req0_src2;
    assign op_sel   = grant1 ? bus.req1_op   : bus.req0_op;

    generate
        if (HI_OPS_EN) begin : g_hi_ops
            assign op_in = op_sel;
        end else begin : g_lo_only
            assign op_in = OP_LO;
        end
    endgenerate

    assign is_lo    = (op_reg == OP_LO);
    assign prod_ext = {32'd0, bus.mul_p};

    assign bus.req0_ready = (state_reg == IDLE) & grant0;
    assign bus.req1_ready = (state_reg == IDLE) & grant1;
    assign bus.rsp_valid  = (state_reg == RSP);
    assign bus.rsp_id     = (state_reg == RSP) ? id_reg : 1'b0;
    assign bus.rsp_data   = (state_reg != RSP) ? 32'd0 : (is_lo ? acc_reg[31:0] : acc_reg[63:32]);
    assign bus.mul_a      = mul_a_reg;
    assign bus.mul_b      = mul_b_reg;
    assign bus.mul_en     = mul_en_reg;

    // Signed corrections turning the unsigned high word into the signed one.
    always_comb begin
        fix_sub = 32'd0;
        if ((op_reg == OP_SS || op_reg == OP_SU) && a_reg[31]) fix_sub = fix_sub + b_reg;
        if (op_reg == OP_SS && b_reg[31]) fix_sub = fix_sub + a_reg;
    end

    // Multiplier operand registers are loaded for the state being entered, so mul_p
    // in each state is the product issued by the previous state.
    always_comb begin
        state_next      = state_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        op_next         = op_reg;
        id_next         = id_reg;
        last_grant_next = last_grant_reg;
        acc_next        = acc_reg;
        mul_a_next      = mul_a_reg;
        mul_b_next      = mul_b_reg;
        mul_en_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant0 | grant1) begin
                    a_next          = src1_sel;
                    b_next          = src2_sel;
                    op_next         = op_in;
                    id_next         = grant1;
                    last_grant_next = grant1;
                    acc_next        = 64'd0;
                    mul_a_next      = src1_sel[15:0];
                    mul_b_next      = src2_sel[15:0];
                    mul_en_next     = 1'b1;
                    state_next      = P0;
                end
            end
            P0: begin
                mul_a_next  = a_reg[15:0];
                mul_b_next  = b_reg[31:16];
                mul_en_next = 1'b1;
                state_next  = P1;
            end
            P1: begin
                acc_next    = acc_reg + prod_ext;
                mul_a_next  = a_reg[31:16];
                mul_b_next  = b_reg[15:0];
                mul_en_next = 1'b1;
                state_next  = P2;
            end
            P2: begin
                acc_next = acc_reg + (prod_ext << 16);
                if (is_lo) begin
                    state_next = ACC;
                end else begin
                    mul_a_next  = a_reg[31:16];
                    mul_b_next  = b_reg[31:16];
                    mul_en_next = 1'b1;
                    state_next  = P3;
                end
            end
            P3: begin
                acc_next   = acc_reg + (prod_ext << 16);
                state_next = ACC;
            end
            ACC: begin
                acc_next   = acc_reg + (is_lo ? (prod_ext << 16) : (prod_ext << 32));
                state_next = is_lo ? RSP : FIX;
            end
            FIX: begin
                acc_next   = {acc_reg[63:32] - fix_sub, acc_reg[31:0]};
                state_next = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            a_reg          <= 32'd0;
            b_reg          <= 32'd0;
            op_reg         <= OP_LO;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
            acc_reg        <= 64'd0;
            mul_a_reg      <= 16'd0;
            mul_b_reg      <= 16'd0;
            mul_en_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            op_reg         <= op_next;
            id_reg         <= id_next;
            last_grant_reg <= last_grant_next;
            acc_reg        <= acc_next;
            mul_a_reg      <= mul_a_next;
            mul_b_reg      <= mul_b_next;
            mul_en_reg     <= mul_en_next;
        end
    end
endmodule

// File: tb/tb_mul_seq_arb.sv
// Randomised bench for mul_seq_arb: a registered 16x16 cell model plus a plain-arithmetic
// reference for the 32x32 results, latencies and grant order.
module tb_mul_seq_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   fails = 0;

    mul_seq_arb_if bus ();

    mul_seq_arb #(.HI_OPS_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mul_en) bus.mul_p <= {16'd0, bus.mul_a} * {16'd0, bus.mul_b};
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [63:0] p;
        case (op)
            2'b00:   p = {32'd0, a} * {32'd0, b};
            2'b01:   p = {32'd0, a} * {32'd0, b};
            2'b10:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: p = {{32{a[31]}}, a} * {32'd0, b};
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic drive_req(input int r, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] op);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_src1 = a; bus.req0_src2 = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_src1 = a; bus.req1_src2 = b; bus.req1_op = op;
        end
    endtask

    function automatic logic rdy(input int r);
        return (r == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one op to its first rsp_valid; lat counts cycles from accept.
    task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, output logic ok, output int lat,
                         output int en_cnt, output logic [31:0] data, output logic id);
        int n;
        @(negedge clk);
        drive_req(r, 1'b1, a, b, op);
        #1;
        n = 0;
        while (!rdy(r) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        ok = rdy(r);
        @(negedge clk);
        drive_req(r, 1'b0, 32'd0, 32'd0, 2'b00);
        lat = 1;
        en_cnt = 0;
        while (!bus.rsp_valid && lat < 30) begin
            if (bus.mul_en) en_cnt++;
            @(negedge clk); lat++;
        end
        data = bus.rsp_data;
        id = bus.rsp_id;
        $display("[TB] op req=%0d a=%h b=%h op=%0d -> data=%h id=%0d lat=%0d", r, a, b, op, data, id, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        tests_run++; if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
        tests_run++; if (bus.rsp_data !== 32'd0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
        tests_run++; if (bus.mul_en !== 1'b0) begin fails++; $display("FAIL reset_mul_en got %b want 0", bus.mul_en); end
        tests_run++; if ({bus.mul_a, bus.mul_b} !== 32'd0) begin fails++; $display("FAIL reset_mul_ops got %h want 0", {bus.mul_a, bus.mul_b}); end
        drive_req(0, 1'b1, 32'd1, 32'd1, 2'b00);
        drive_req(1, 1'b1, 32'd1, 32'd1, 2'b00);
        #1;
        tests_run++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin fails++; $display("FAIL reset_first_grant got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        $display("[TB] reset checked");
        drive_req(0, 1'b0, 32'd0, 32'd0, 2'b00);
        drive_req(1, 1'b0, 32'd0, 32'd0, 2'b00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lo_basic();
        logic ok; int lat, en; logic [31:0] d; logic id;
        issue(0, 32'h00010002, 32'h00030004, 2'b00, ok, lat, en, d, id);
        tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL lo_accept got %b want 1", ok); end
        tests_run++; if (lat != 5) begin fails++; $display("FAIL lo_latency got %0d want 5", lat); end
        tests_run++; if (en != 3) begin fails++; $display("FAIL lo_mul_en_cycles got %0d want 3", en); end
        tests_run++; if (d !== 32'h000A0008) begin fails++; $display("FAIL lo_data got %h want 000a0008", d); end
        tests_run++; if (id !== 1'b0) begin fails++; $display("FAIL lo_id got %b want 0", id); end
    endtask

    task automatic test_hi_uu();
        logic ok; int lat, en; logic [31:0] d; logic id;
        issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, ok, lat, en, d, id);
        tests_run++; if (lat != 7) begin fails++; $display("FAIL hiuu_latency got %0d want 7", lat); end
        tests_run++; if (en != 4) begin fails++; $display("FAIL hiuu_mul_en_cycles got %0d want 4", en); end
        tests_run++; if (d !== 32'hFFFFFFFE) begin fails++; $display("FAIL hiuu_data got %h want fffffffe", d); end
        tests_run++; if (id !== 1'b1) begin fails++; $display("FAIL hiuu_id got %b want 1", id); end
    endtask

    task automatic test_hi_signed();
        logic [31:0] ta [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] tb [3] = '{32'h00000002, 32'hFFFFFFFF, 32'h80000000};
        logic [1:0]  to [3] = '{2'b10, 2'b11, 2'b10};
        logic [31:0] te [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000};
        logic ok; int lat, en; logic [31:0] d; logic id;
        for (int i = 0; i < 3; i++) begin
            issue(0, ta[i], tb[i], to[i], ok, lat, en, d, id);
            tests_run++; if (d !== te[i]) begin fails++; $display("FAIL hi_signed_%0d got %h want %h", i, d, te[i]); end
            tests_run++; if (lat != 7) begin fails++; $display("FAIL hi_signed_lat_%0d got %0d want 7", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ca [2];
        logic [31:0] cb [2];
        logic [1:0]  co [2];
        int          grants[$];
        logic [31:0] exp_q[$];
        int          id_q[$];
        int          nrsp, cyc, chg, g;
        logic        overlap;
        logic [31:0] ed;
        int          eid;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            ca[r] = $urandom; cb[r] = $urandom; co[r] = 2'($urandom_range(0, 3));
        end
        nrsp = 0; cyc = 0; chg = -1; overlap = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, ca[0], cb[0], co[0]);
        drive_req(1, 1'b1, ca[1], cb[1], co[1]);
        while (nrsp < 3 && cyc < 100) begin
            if (chg >= 0) begin
                ca[chg] = $urandom; cb[chg] = $urandom; co[chg] = 2'($urandom_range(0, 3));
                drive_req(chg, 1'b1, ca[chg], cb[chg], co[chg]);
                chg = -1;
            end
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                if ((bus.req0_ready && bus.req1_ready) || bus.mul_en) overlap = 1'b1;
                g = bus.req0_ready ? 0 : 1;
                grants.push_back(g);
                exp_q.push_back(model(ca[g], cb[g], co[g]));
                id_q.push_back(g);
                chg = g;
            end
            if (bus.rsp_valid) begin
                if (bus.mul_en) overlap = 1'b1;
                ed = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                eid = (id_q.size() > 0) ? id_q.pop_front() : 2;
                $display("[TB] b2b rsp id=%0d data=%h", bus.rsp_id, bus.rsp_data);
                tests_run++; if (bus.rsp_data !== ed) begin fails++; $display("FAIL b2b_data_%0d got %h want %h", nrsp, bus.rsp_data, ed); end
                tests_run++; if (int'(bus.rsp_id) != eid) begin fails++; $display("FAIL b2b_id_%0d got %0d want %0d", nrsp, bus.rsp_id, eid); end
                nrsp++;
                if (nrsp == 3) begin
                    drive_req(0, 1'b0, 32'd0, 32'd0, 2'b00);
                    drive_req(1, 1'b0, 32'd0, 32'd0, 2'b00);
                end
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++; if (nrsp != 3) begin fails++; $display("FAIL b2b_timeout got %0d responses want 3", nrsp); end
        tests_run++;
        if (grants.size() < 3 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin
            fails++; $display("FAIL b2b_grant_order got %p want 0,1,0", grants);
        end
        tests_run++; if (overlap !== 1'b0) begin fails++; $display("FAIL b2b_overlap got %b want 0", overlap); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, a2, b2, d0;
        logic [1:0]  op2;
        logic        i0;
        int          n;
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom; op2 = 2'($urandom_range(0, 3));
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, a, b, 2'b00);
        #1;
        n = 0;
        while (!bus.req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_req(0, 1'b0, 32'd0, 32'd0, 2'b00);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        d0 = bus.rsp_data; i0 = bus.rsp_id;
        tests_run++; if (d0 !== model(a, b, 2'b00)) begin fails++; $display("FAIL bp_data got %h want %h", d0, model(a, b, 2'b00)); end
        tests_run++; if (i0 !== 1'b0) begin fails++; $display("FAIL bp_id got %b want 0", i0); end
        drive_req(1, 1'b1, a2, b2, op2);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 || bus.rsp_id !== i0) begin
                fails++; $display("FAIL bp_hold_%0d got v=%b d=%h id=%b want v=1 d=%h id=%b", k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, d0, i0);
            end
            tests_run++;
            if ({bus.req0_ready, bus.req1_ready, bus.mul_en} !== 3'b000) begin
                fails++; $display("FAIL bp_quiet_%0d got %b want 000", k, {bus.req0_ready, bus.req1_ready, bus.mul_en});
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        tests_run++;
        if ({bus.rsp_valid, bus.req1_ready} !== 2'b01) begin
            fails++; $display("FAIL bp_idle_after_ready got %b want 01", {bus.rsp_valid, bus.req1_ready});
        end
        @(negedge clk);
        drive_req(1, 1'b0, 32'd0, 32'd0, 2'b00);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        $display("[TB] bp follow-on id=%0d data=%h", bus.rsp_id, bus.rsp_data);
        tests_run++; if (bus.rsp_data !== model(a2, b2, op2)) begin fails++; $display("FAIL bp_next_data got %h want %h", bus.rsp_data, model(a2, b2, op2)); end
        tests_run++; if (bus.rsp_id !== 1'b1) begin fails++; $display("FAIL bp_next_id got %b want 1", bus.rsp_id); end
    endtask

    task automatic test_reset_midop();
        logic ok; int lat, en, n; logic [31:0] d; logic id; logic seen;
        @(negedge clk);
        drive_req(1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 2'b01);
        #1;
        n = 0;
        while (!bus.req1_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        drive_req(1, 1'b0, 32'd0, 32'd0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (bus.mul_en !== 1'b1) begin fails++; $display("FAIL midop_in_p2 mul_en got %b want 1", bus.mul_en); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (bus.mul_en || bus.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (seen !== 1'b0) begin fails++; $display("FAIL midop_discard got activity=%b want 0", seen); end
        issue(0, 32'd3, 32'd5, 2'b00, ok, lat, en, d, id);
        tests_run++; if (d !== 32'd15) begin fails++; $display("FAIL midop_next_data got %h want 0000000f", d); end
        tests_run++; if (lat != 5) begin fails++; $display("FAIL midop_next_lat got %0d want 5", lat); end
        tests_run++; if (id !== 1'b0) begin fails++; $display("FAIL midop_next_id got %b want 0", id); end
    endtask

    task automatic test_random();
        logic ok; int lat, en, r; logic [31:0] d, a, b, e; logic id; logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            op = 2'($urandom_range(0, 3));
            if (i % 6 == 1) a = 32'h80000000;
            if (i % 6 == 2) b = 32'hFFFFFFFF;
            if (i % 6 == 3) a = 32'd0;
            e = model(a, b, op);
            issue(r, a, b, op, ok, lat, en, d, id);
            tests_run++; if (d !== e) begin fails++; $display("FAIL rand_data_%0d got %h want %h", i, d, e); end
            tests_run++; if (int'(id) != r) begin fails++; $display("FAIL rand_id_%0d got %0d want %0d", i, id, r); end
            tests_run++; if (lat != ((op == 2'b00) ? 5 : 7)) begin fails++; $display("FAIL rand_lat_%0d got %0d want %0d", i, lat, (op == 2'b00) ? 5 : 7); end
        end
    endtask

    initial begin
        bus.rsp_ready = 1'b1;
        bus.mul_p = 32'd0;
        drive_req(0, 1'b0, 32'd0, 32'd0, 2'b00);
        drive_req(1, 1'b0, 32'd0, 32'd0, 2'b00);
        test_reset();
        test_lo_basic();
        test_hi_uu();
        test_hi_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
